// File: rtl/uart_word_bridge_pkg.sv
// Shared encodings and defaults for the UART byte <-> word bridge.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package uart_word_bridge_pkg;

    localparam int DEF_NBYTES    = 4;
    localparam int DEF_GAP_TICKS = 50000;
    localparam int DEF_GAP_BIT   = 16;

    typedef enum logic {
        RX_COLLECT = 1'b0,
        RX_HOLD    = 1'b1
    } rx_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    // Byte-index width; a one-byte word still needs a 1-bit index register.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

    localparam int DEF_IDX_W = idx_width(DEF_NBYTES);

endpackage

// File: rtl/bridge_gap_timer.sv
// Inter-byte silence timer: counts enabled cycles, flags the last allowed one.
// Latency: expired is combinational from the count register (same cycle).
// Backpressure: none; clear wins over enable, and the count self-clears on expiry.
module bridge_gap_timer
    import uart_word_bridge_pkg::*;
#(
    parameter int GAP_TICKS = DEF_GAP_TICKS,
    parameter int GAP_BIT   = DEF_GAP_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [GAP_BIT-1:0] LAST = GAP_BIT'(GAP_TICKS - 1);

    logic [GAP_BIT-1:0] cnt;

    assign expired = enable && (cnt == LAST);

    // Count idle cycles; restart on clear or once the limit has been hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || expired) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_word_bridge.sv
// Packs UART RX bytes into little-endian words and serialises words to UART TX bytes.
// Latency: rx_word_valid 1 cycle after the last byte pops; TX pushes start 1 cycle after accept (NBYTES+1 cycles/word).
// Backpressure: RX holds the word (no pops) until rx_word_ready; TX stalls in place while tx_full.
module uart_word_bridge
    import uart_word_bridge_pkg::*;
#(
    parameter int NBYTES    = DEF_NBYTES,
    parameter int GAP_TICKS = DEF_GAP_TICKS,
    parameter int GAP_BIT   = DEF_GAP_BIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_empty,
    input  logic [7:0]            r_data,
    output logic                  rd_uart,
    input  logic                  tx_full,
    output logic [7:0]            w_data,
    output logic                  wr_uart,
    output logic [8*NBYTES-1:0]   rx_word,
    output logic                  rx_word_valid,
    input  logic                  rx_word_ready,
    input  logic [8*NBYTES-1:0]   tx_word,
    input  logic                  tx_word_valid,
    output logic                  tx_word_ready
);

    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    // ---------------- RX path ----------------
    rx_state_t        rx_state;
    logic [IDX_W-1:0] rx_idx;
    logic             rx_pop;
    logic             gap_clear;
    logic             gap_en;
    logic             gap_expired;

    // Outputs are qualified by reset so nothing leaks while it is held low.
    assign rx_pop        = reset && (rx_state == RX_COLLECT) && !rx_empty;
    assign rd_uart       = rx_pop;
    assign rx_word_valid = reset && (rx_state == RX_HOLD);

    // Timer only runs while a partial word is waiting on an empty FIFO.
    assign gap_en    = (rx_state == RX_COLLECT) && (rx_idx != '0) && rx_empty;
    assign gap_clear = rx_pop || (rx_state == RX_HOLD) || (rx_idx == '0);

    bridge_gap_timer #(
        .GAP_TICKS (GAP_TICKS),
        .GAP_BIT   (GAP_BIT)
    ) u_gap_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (gap_clear),
        .enable  (gap_en),
        .expired (gap_expired)
    );

    // Collect bytes into their little-endian slot, hold the full word until taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_COLLECT;
            rx_idx   <= '0;
            rx_word  <= '0;
        end else begin
            case (rx_state)
                RX_COLLECT: begin
                    if (rx_pop) begin
                        rx_word[{rx_idx, 3'b000} +: 8] <= r_data;
                        if (rx_idx == LAST_IDX) begin
                            rx_idx   <= '0;
                            rx_state <= RX_HOLD;
                        end else begin
                            rx_idx <= rx_idx + 1'b1;
                        end
                    end else if (gap_expired) begin
                        rx_idx <= '0;
                    end
                end
                RX_HOLD: begin
                    if (rx_word_ready) begin
                        rx_state <= RX_COLLECT;
                    end
                end
                default: rx_state <= RX_COLLECT;
            endcase
        end
    end

    // ---------------- TX path ----------------
    tx_state_t        tx_state;
    logic [IDX_W-1:0] tx_idx;
    logic [W-1:0]     shift;
    logic             tx_push;

    assign tx_word_ready = reset && (tx_state == TX_IDLE);
    assign tx_push       = reset && (tx_state == TX_SEND) && !tx_full;
    assign wr_uart       = tx_push;
    assign w_data        = reset ? shift[7:0] : 8'h00;

    // Load a word on handshake, then shift out one byte per non-full cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_idx   <= '0;
            shift    <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_word_valid) begin
                        shift    <= tx_word;
                        tx_idx   <= '0;
                        tx_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (tx_push) begin
                        shift <= shift >> 8;
                        if (tx_idx == LAST_IDX) begin
                            tx_idx   <= '0;
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_idx <= tx_idx + 1'b1;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_word_bridge.md
UART_WORD_BRIDGE -- requirements
Module: uart_word_bridge

Interface
REQ-001 Parameter NBYTES, default 4: bytes per word; word width W = 8*NBYTES.
REQ-002 Parameter GAP_TICKS, default 50000: idle clk cycles allowed between bytes of a partial RX word.
REQ-003 Parameter GAP_BIT, default 16: width of the gap counter.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 rx_empty  input  1  UART RX FIFO empty.
REQ-007 r_data  input  8  UART RX FIFO head byte, valid while rx_empty=0.
REQ-008 rd_uart  output  1  pop UART RX FIFO.
REQ-009 tx_full  input  1  UART TX FIFO full.
REQ-010 w_data  output  8  byte pushed to UART TX FIFO.
REQ-011 wr_uart  output  1  push UART TX FIFO.
REQ-012 rx_word  output  W  assembled received word.
REQ-013 rx_word_valid  output  1  rx_word is held and valid.
REQ-014 rx_word_ready  input  1  consumer accepts rx_word.
REQ-015 tx_word  input  W  word to transmit.
REQ-016 tx_word_valid  input  1  tx_word offered.
REQ-017 tx_word_ready  output  1  bridge can accept tx_word.

Function
REQ-018 RX and TX paths are independent; they shall operate concurrently with no shared state.
REQ-019 RX FSM states: COLLECT, HOLD.
REQ-020 In COLLECT, rd_uart = ~rx_empty (combinational); on the same edge, r_data is stored into byte slot rx_idx and rx_idx increments.
REQ-021 Byte order is little-endian: first byte received -> rx_word[7:0].
REQ-022 When the NBYTES-th byte pops, the FSM enters HOLD; rx_word_valid = 1 on the next cycle.
REQ-023 In HOLD, rd_uart = 0 and rx_word stays stable; on rx_word_valid & rx_word_ready the FSM returns to COLLECT with rx_idx = 0.
REQ-024 Gap counter: clears on each pop; increments in COLLECT while rx_idx != 0 and rx_empty = 1.
REQ-025 When the gap counter reaches GAP_TICKS-1, the partial word shall be discarded: rx_idx = 0, counter = 0, no valid raised.
REQ-026 Gap counter is idle (held at 0) when rx_idx = 0 and in HOLD.
REQ-027 TX FSM states: IDLE, SEND.
REQ-028 tx_word_ready = 1 exactly in IDLE; on tx_word_valid & tx_word_ready, tx_word loads the shift register, tx_idx = 0, FSM enters SEND.
REQ-029 In SEND, w_data = shift[7:0] and wr_uart = ~tx_full (combinational); each push shifts right by 8 and increments tx_idx.
REQ-030 On the NBYTES-th push the FSM returns to IDLE; tx_word_ready = 1 on the next cycle. Back-to-back throughput: NBYTES + 1 cycles per word with tx_full = 0.
REQ-031 tx_full = 1 stalls SEND with no push and shift/index unchanged; wr_uart is never asserted while tx_full = 1.
REQ-032 rd_uart is never asserted while rx_empty = 1.

Reset
REQ-033 While reset = 0, the following shall hold: RX = COLLECT, TX = IDLE, rx_idx = tx_idx = gap = 0, rx_word = 0, shift = 0.
REQ-034 While reset = 0, the following outputs shall be forced to 0: rd_uart, wr_uart, rx_word_valid, tx_word_ready, w_data. Outputs are gated by reset regardless of FIFO flags.
REQ-035 Reset mid-word shall abandon partial RX/TX words; bytes already pushed or popped are not recovered.

Structure
REQ-036 The shared package shall hold the RX/TX state encodings, default NBYTES and GAP_TICKS, and the byte-index width clog2(NBYTES).
REQ-037 The gap timer shall be a separate sub-module, bridge_gap_timer (clear, enable, terminal-count output), used by the RX path.

Verification
REQ-038 Scenario 1: RX FIFO supplies 0x78,0x56,0x34,0x12 back-to-back -> exactly 4 rd_uart pulses, then rx_word = 0x12345678 with rx_word_valid one cycle after the 4th pop.
REQ-039 Scenario 2: tx_word = 0xDEADBEEF with valid, tx_full = 0 -> wr_uart for 4 consecutive cycles with w_data = EF,BE,AD,DE; ready returns in cycle 5.
REQ-040 Scenario 3: tx_full is held at 1 for 10 cycles after the second byte -> no push during the stall; resumes with 0xAD; total 4 pushes.
REQ-041 Scenario 4: 2 bytes arrive, then silence for GAP_TICKS=20 cycles, then 0x01,0x02,0x03,0x04 -> rx_word = 0x04030201; no word is formed from the stale bytes.
REQ-042 Scenario 5: a word is held with rx_word_ready = 0 while 3 more bytes sit in the FIFO -> no rd_uart until the handshake; the next word then assembles correctly.
REQ-043 Scenario 6: reset is asserted after the second TX push and the second RX pop -> all outputs go to 0 immediately; after release, ready = 1 and a fresh word transfers correctly.
